// File: rtl/div32_pkg.sv
// div32_pkg: shared types and constants for the sequential restoring divider.
// Optional feature macro: DIV32_SIGNED_EN (two's-complement support in div32_seq).
package div32_pkg;

   // Default operand/result width of the divider.
   localparam int DEFAULT_WIDTH = 32;

   // Divide-by-zero quotient is all ones; replicate this fill bit to WIDTH.
   localparam logic DIV0_QUOTIENT_FILL = 1'b1;

   // Controller states of the divider.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      FINISH  = 2'd2,
      SPECIAL = 2'd3
   } state_t;

endpackage : div32_pkg

// File: rtl/div32_step.sv
// div32_step: one combinational restoring shift-subtract iteration.
// The partial remainder is shifted left with the next dividend bit, then the
// divisor is trial-subtracted in WIDTH+1 bits. Because the incoming remainder
// is always below the divisor, the shifted value is below twice the divisor,
// so the MSB of the WIDTH+1-bit difference is a reliable borrow flag.
module div32_step
   import div32_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic             i_bit,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_q_bit
);

   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_diff;

   assign w_shift = {i_rem, i_bit};
   assign w_diff  = w_shift - {1'b0, i_divisor};

   // Non-negative difference: quotient bit 1 and keep the difference;
   // otherwise quotient bit 0 and restore the shifted remainder.
   assign o_q_bit = ~w_diff[WIDTH];
   assign o_rem   = o_q_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule : div32_step

// File: rtl/div32_seq.sv
// div32_seq: multi-cycle integer divider, one quotient bit per clock.
// Handshake: start (sampled in IDLE) / busy / one-cycle done pulse.
// Optional feature macro: DIV32_SIGNED_EN. When defined, signed_op selects a
// two's-complement divide truncating toward zero; when undefined, every
// operation is unsigned and overflow is tied low.
module div32_seq
   import div32_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero,
   output logic             overflow
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_rem;        // partial remainder during RUN
   logic [WIDTH-1:0] r_dvd;        // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] r_divisor;    // divisor magnitude
   logic [WIDTH-1:0] r_a;          // original dividend, for divide-by-zero remainder
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_div_zero;
   logic             r_done;

   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic             w_ovf_cond;
   logic [WIDTH-1:0] w_step_rem;
   logic             w_step_q;

`ifdef DIV32_SIGNED_EN
   logic             r_neg_q;      // quotient needs negation after RUN
   logic             r_neg_r;      // remainder needs negation (follows sign of a)
   logic             r_overflow;
   logic             w_a_neg;
   logic             w_b_neg;

   assign w_a_neg = signed_op & a[WIDTH-1];
   assign w_b_neg = signed_op & b[WIDTH-1];
   // |MIN| wraps back to MIN, which is the correct unsigned magnitude.
   assign w_a_mag = w_a_neg ? -a : a;
   assign w_b_mag = w_b_neg ? -b : b;
   assign w_ovf_cond = signed_op & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (&b);
   assign overflow   = r_overflow;
`else
   // signed_op has no function in the unsigned-only build.
   logic             w_unused_signed_op;

   assign w_unused_signed_op = signed_op;
   assign w_a_mag    = a;
   assign w_b_mag    = b;
   assign w_ovf_cond = 1'b0;
   assign overflow   = 1'b0;
`endif

   // Single restoring iteration, reused every RUN cycle.
   div32_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .i_rem    (r_rem),
      .i_bit    (r_dvd[WIDTH-1]),
      .i_divisor(r_divisor),
      .o_rem    (w_step_rem),
      .o_q_bit  (w_step_q)
   );

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode and busy output.
   // NOTE: defaults are assigned first so no path leaves a signal unassigned (no inferred latch).
   always_comb begin
      w_next_state = r_state;
      busy         = 1'b1;
      unique case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_next_state = ((b == '0) || w_ovf_cond) ? SPECIAL : RUN;
            end
         end
         RUN: begin
            if (r_count == '0) begin
               w_next_state = FINISH;
            end
         end
         FINISH:  w_next_state = IDLE;
         SPECIAL: w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Operand capture, iteration, result registration and done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count     <= '0;
         r_rem       <= '0;
         r_dvd       <= '0;
         r_divisor   <= '0;
         r_a         <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_div_zero  <= 1'b0;
         r_done      <= 1'b0;
`ifdef DIV32_SIGNED_EN
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_overflow  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_a        <= a;
                  r_dvd      <= w_a_mag;
                  r_divisor  <= w_b_mag;
                  r_rem      <= '0;
                  r_count    <= CNT_W'(WIDTH - 1);
                  r_div_zero <= 1'b0;
`ifdef DIV32_SIGNED_EN
                  r_neg_q    <= w_a_neg ^ w_b_neg;
                  r_neg_r    <= w_a_neg;
                  r_overflow <= 1'b0;
`endif
               end
            end
            RUN: begin
               r_rem   <= w_step_rem;
               r_dvd   <= {r_dvd[WIDTH-2:0], w_step_q};
               r_count <= r_count - CNT_W'(1);
            end
            FINISH: begin
`ifdef DIV32_SIGNED_EN
               r_quotient  <= r_neg_q ? -r_dvd : r_dvd;
               r_remainder <= r_neg_r ? -r_rem : r_rem;
`else
               r_quotient  <= r_dvd;
               r_remainder <= r_rem;
`endif
               r_done      <= 1'b1;
            end
            SPECIAL: begin
               if (r_divisor == '0) begin
                  // Divide by zero, signed or unsigned.
                  r_quotient  <= {WIDTH{DIV0_QUOTIENT_FILL}};
                  r_remainder <= r_a;
                  r_div_zero  <= 1'b1;
               end else begin
                  // Signed MIN / -1: quotient saturates to the dividend.
                  r_quotient  <= r_a;
                  r_remainder <= '0;
`ifdef DIV32_SIGNED_EN
                  r_overflow  <= 1'b1;
`endif
               end
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign done      = r_done;
   assign quotient  = r_quotient;
   assign remainder = r_remainder;
   assign div_zero  = r_div_zero;

endmodule : div32_seq

// File: doc/div32_seq.md
Name: div32_seq

Overview:
Multi-cycle 32-bit integer divider, the inverse-operation partner to the combinational add/sub ALU.
- Restoring shift-subtract algorithm, one quotient bit per clock.
- Produces quotient, remainder and exception flags.
- Sits beside the ALU in the datapath; a start/busy/done handshake lets a controller stall while the divide runs.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when not busy
- signed_op  input  1  1 = two's-complement divide, 0 = unsigned (see Optional Feature)
- a  input  WIDTH  dividend, captured on accepted start
- b  input  WIDTH  divisor, captured on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results become valid
- quotient  output  WIDTH  result, held until next accepted start
- remainder  output  WIDTH  result, held until next accepted start
- div_zero  output  1  divisor was zero; held with results
- overflow  output  1  signed MIN / −1; held with results

Behaviour:
- Reset (async, any state): state = IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, div_zero = 0, overflow = 0, counter = 0. Reset mid-RUN aborts the operation with no done pulse.
- States:
  - IDLE: start = 1 captures a, b, signed_op. Next state is SPECIAL if b == 0 or signed overflow, else RUN.
  - RUN: WIDTH iterations. Each iteration shifts {rem, dividend} left by 1, then trial-subtracts the divisor magnitude using a WIDTH+1-bit subtract. A non-negative difference sets the quotient bit to 1 and keeps the difference; otherwise the bit is 0 and the old value is restored. The counter counts from WIDTH−1 to 0; leave RUN after the count-0 iteration.
  - FINISH: apply sign fixup, register outputs, done = 1, next state IDLE.
  - SPECIAL: register exception results, done = 1, next state IDLE.
- busy = 1 in RUN, FINISH and SPECIAL; 0 in IDLE.
- done is registered and high for exactly one cycle.
- Latency: start accepted at edge k.
  - Normal path: done is high in the cycle following edge k+WIDTH+1 (WIDTH+2 edges inclusive).
  - Special path: done is high after edge k+1.
- start while busy is ignored, with no effect on captured operands. start in the same cycle done is high is accepted, because state is already IDLE on that edge.
- Divide by zero: quotient = all ones, remainder = a, div_zero = 1, overflow = 0. Applies to both signed and unsigned.
- Signed overflow (signed_op = 1, a = 100…0, b = all ones): quotient = a, remainder = 0, overflow = 1.
- Signed normal path:
  - Divide the magnitudes |a| and |b|.
  - Quotient is negated if sign(a) ≠ sign(b).
  - Remainder takes the sign of a, so truncation is toward zero.
  - |MIN| is computed in WIDTH bits unsigned, which is correct.
- Flags are cleared on the next accepted start.
- Outputs quotient and remainder change only on a FINISH or SPECIAL edge.

Optional Feature:
- Macro: DIV32_SIGNED_EN.
- Defined: signed_op is honoured as described above.
- Undefined:
  - signed_op is ignored and every operation is unsigned.
  - The overflow output is tied to 0.
  - Sign/negate logic is not generated.
- Port list is identical in both builds.

Decomposition:
- Shared package div32_pkg:
  - state enum: IDLE, RUN, FINISH, SPECIAL
  - default WIDTH constant
  - DIV0 quotient constant: all ones
- Sub-module div32_step:
  - combinational single restoring iteration
  - inputs: partial remainder, next dividend bit, divisor
  - outputs: new remainder, quotient bit
  - instantiated once by div32_seq

Test Plan:
- Unsigned: a = 100, b = 7, signed_op = 0 → q = 14, r = 2; done exactly WIDTH+2 edges after start; busy high throughout.
- Divide by zero: a = 0x1234, b = 0 → q = 0xFFFFFFFF, r = 0x1234, div_zero = 1, done after 2 edges.
- Signed: a = −7, b = 2 → q = −3 (0xFFFFFFFD), r = −1. a = 7, b = −2 → q = −3, r = 1.
- Signed overflow: a = 0x80000000, b = 0xFFFFFFFF → q = 0x80000000, r = 0, overflow = 1. With the macro undefined, the same operands give q = 0, r = 0x80000000, overflow = 0.
- Handshake:
  - start pulsed mid-RUN with new operands → ignored; first result unchanged.
  - start asserted in the done cycle → second op accepted back-to-back.
- Reset: assert rst at iteration 10 → all outputs 0 immediately, no done pulse; a fresh op after release gives correct results.
